// File: rtl/aes_dec_control.sv
// Sequencing controller for the AES-256 decryption datapath: forward key expansion
// to the last round key, then inverse rounds with the round keys walked backwards.
module aes_dec_control #(
  parameter int NUM_ROUNDS = 14,
  parameter int CNT_W      = 4
) (
  input  logic             inClk,
  input  logic             inRstN,
  input  logic             inExtKeyWr,
  input  logic             inExtDataWr,
  output logic             outIntRoundRegExtWr,
  output logic             outIntRoundRegIntWr,
  output logic             outIntDataOutRegWr,
  output logic             outKeyExpFwd,
  output logic             outKeyExpRev,
  output logic             outKeySave,
  output logic             outKeyRestore,
  output logic             outLastRound,
  output logic [CNT_W-1:0] outRoundIdx,
  output logic             outKeyReady,
  output logic             outBusy,
  output logic [1:0]       outDbgState
);

  typedef enum logic [1:0] {IDLE = 2'd0, KEYEXP = 2'd1, DECRYPT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] CNT_DEC0 = CNT_W'(NUM_ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             key_valid, key_valid_nxt;

  logic             ext_wr, int_wr, out_wr, fwd, rev, save, restore, last;
  logic [CNT_W-1:0] idx;
  logic             busy;

  // Handshake: inExtKeyWr / inExtDataWr are single-cycle strobes sampled only in
  // IDLE; a data strobe is accepted only while the expanded key is valid, and a
  // key strobe in the same cycle wins. Both are ignored while busy.
  always_ff @(posedge inClk) begin
    if (!inRstN) begin
      state     <= IDLE;
      cnt       <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      key_valid <= key_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    key_valid_nxt = key_valid;
    ext_wr        = 1'b0;
    int_wr        = 1'b0;
    out_wr        = 1'b0;
    fwd           = 1'b0;
    rev           = 1'b0;
    save          = 1'b0;
    restore       = 1'b0;
    last          = 1'b0;
    idx           = '0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        if (inExtKeyWr) begin
          key_valid_nxt = 1'b0;
          cnt_nxt       = CNT_ONE;
          state_nxt     = KEYEXP;
        end else if (inExtDataWr && key_valid) begin
          ext_wr    = 1'b1;
          cnt_nxt   = CNT_DEC0;
          state_nxt = DECRYPT;
        end
      end
      KEYEXP: begin
        busy = 1'b1;
        fwd  = 1'b1;
        idx  = cnt;
        if (cnt < CNT_LAST) begin
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          save          = 1'b1;
          key_valid_nxt = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = IDLE;
        end
      end
      DECRYPT: begin
        busy   = 1'b1;
        int_wr = 1'b1;
        rev    = 1'b1;
        idx    = cnt;
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          // Final inverse round: restore shares the cycle with the reverse step;
          // the key datapath gives restore priority.
          last      = 1'b1;
          out_wr    = 1'b1;
          restore   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Every output is forced low while reset is asserted.
  assign outIntRoundRegExtWr = inRstN & ext_wr;
  assign outIntRoundRegIntWr = inRstN & int_wr;
  assign outIntDataOutRegWr  = inRstN & out_wr;
  assign outKeyExpFwd        = inRstN & fwd;
  assign outKeyExpRev        = inRstN & rev;
  assign outKeySave          = inRstN & save;
  assign outKeyRestore       = inRstN & restore;
  assign outLastRound        = inRstN & last;
  assign outRoundIdx         = inRstN ? idx : '0;
  assign outKeyReady         = inRstN & key_valid;
  assign outBusy             = inRstN & busy;
  assign outDbgState         = inRstN ? state : 2'b00;

endmodule

// File: tb/tb_aes_dec_control.sv
// Self-checking bench for aes_dec_control: directed scenarios followed by random
// strobes, each cycle compared against a schedule-based reference model.
module tb_aes_dec_control;

  localparam int NR = 14;
  localparam int W  = 14;

  logic       inClk;
  logic       inRstN;
  logic       inExtKeyWr;
  logic       inExtDataWr;
  logic       outIntRoundRegExtWr, outIntRoundRegIntWr, outIntDataOutRegWr;
  logic       outKeyExpFwd, outKeyExpRev, outKeySave, outKeyRestore, outLastRound;
  logic [3:0] outRoundIdx;
  logic       outKeyReady, outBusy;
  logic [1:0] outDbgState;

  typedef struct packed {
    logic       ext_wr;
    logic       int_wr;
    logic       out_wr;
    logic       fwd;
    logic       rev;
    logic       save;
    logic       restore;
    logic       last;
    logic [3:0] idx;
    logic       ready;
    logic       busy;
  } outs_t;

  aes_dec_control #(.NUM_ROUNDS(NR), .CNT_W(4)) dut (
    .inClk              (inClk),
    .inRstN             (inRstN),
    .inExtKeyWr         (inExtKeyWr),
    .inExtDataWr        (inExtDataWr),
    .outIntRoundRegExtWr(outIntRoundRegExtWr),
    .outIntRoundRegIntWr(outIntRoundRegIntWr),
    .outIntDataOutRegWr (outIntDataOutRegWr),
    .outKeyExpFwd       (outKeyExpFwd),
    .outKeyExpRev       (outKeyExpRev),
    .outKeySave         (outKeySave),
    .outKeyRestore      (outKeyRestore),
    .outLastRound       (outLastRound),
    .outRoundIdx        (outRoundIdx),
    .outKeyReady        (outKeyReady),
    .outBusy            (outBusy),
    .outDbgState        (outDbgState)
  );

  // clock / reset
  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  // scoreboard: exp_q holds the planned per-cycle outputs of the running operation
  logic [W-1:0] exp_q[$];
  logic         model_ready;
  int           n_checks;
  int           n_fails;

  function automatic outs_t model_step(input logic key, input logic data, input logic rstn);
    outs_t e;
    e = '0;
    if (!rstn) begin
      exp_q.delete();
      model_ready = 1'b0;
    end else if (exp_q.size() > 0) begin
      e       = outs_t'(exp_q.pop_front());
      e.ready = model_ready;
      if (e.save) model_ready = 1'b1;
    end else begin
      e.ready = model_ready;
      if (key) begin
        model_ready = 1'b0;
        for (int i = 1; i <= NR; i++) begin
          outs_t p;
          p      = '0;
          p.busy = 1'b1;
          p.fwd  = 1'b1;
          p.idx  = 4'(i);
          p.save = (i == NR);
          exp_q.push_back(W'(p));
        end
      end else if (data && model_ready) begin
        e.ext_wr = 1'b1;
        for (int r = NR - 1; r >= 0; r--) begin
          outs_t p;
          p         = '0;
          p.busy    = 1'b1;
          p.int_wr  = 1'b1;
          p.rev     = 1'b1;
          p.idx     = 4'(r);
          p.last    = (r == 0);
          p.out_wr  = (r == 0);
          p.restore = (r == 0);
          exp_q.push_back(W'(p));
        end
      end
    end
    return e;
  endfunction

  // driver: one clock cycle with the given inputs, checked mid-cycle
  task automatic cycle(input logic key, input logic data, input logic rstn, input string tag);
    outs_t obs, exp;
    inExtKeyWr  = key;
    inExtDataWr = data;
    inRstN      = rstn;
    #3;
    obs = '{outIntRoundRegExtWr, outIntRoundRegIntWr, outIntDataOutRegWr, outKeyExpFwd,
            outKeyExpRev, outKeySave, outKeyRestore, outLastRound, outRoundIdx,
            outKeyReady, outBusy};
    exp = model_step(key, data, rstn);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    @(posedge inClk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    model_ready = 1'b0;
    inRstN      = 1'b0;
    inExtKeyWr  = 1'b0;
    inExtDataWr = 1'b0;
    @(posedge inClk);
    #1;
    cycle(1'b0, 1'b0, 1'b0, "reset");
    cycle(1'b1, 1'b1, 1'b0, "reset_strobes");
    idle(2, "after_reset");

    // data before any key is ignored
    cycle(1'b0, 1'b1, 1'b1, "data_no_key");
    idle(2, "data_no_key_idle");

    // key expansion
    cycle(1'b1, 1'b0, 1'b1, "key_wr");
    idle(NR + 2, "keyexp");

    // one block, with strobes injected at T+5 that must be ignored
    cycle(1'b0, 1'b1, 1'b1, "data_T");
    idle(4, "dec");
    cycle(1'b1, 1'b1, 1'b1, "dec_ignore_T5");
    idle(NR - 5 + 2, "dec_tail");

    // back-to-back blocks: data at T and T+15
    cycle(1'b0, 1'b1, 1'b1, "b2b_first");
    idle(NR, "b2b_dec1");
    cycle(1'b0, 1'b1, 1'b1, "b2b_second");
    idle(NR + 1, "b2b_dec2");

    // reset in the middle of a decrypt
    cycle(1'b0, 1'b1, 1'b1, "rst_data_T");
    idle(6, "rst_dec");
    cycle(1'b0, 1'b0, 1'b0, "rst_mid_dec");
    idle(NR + 1, "after_mid_rst");
    cycle(1'b0, 1'b1, 1'b1, "data_after_rst");
    idle(2, "data_after_rst_idle");

    // key and data in the same idle cycle: key wins
    cycle(1'b1, 1'b1, 1'b1, "key_and_data");
    idle(NR + 1, "keyexp2");
    cycle(1'b0, 1'b1, 1'b1, "data_after_key2");
    idle(NR + 1, "dec3");

    // random strobes
    for (int i = 0; i < 3000; i++) begin
      logic k, d, r;
      k = ($urandom_range(0, 39) == 0);
      d = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 199) != 0);
      cycle(k, d, r, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/aes_dec_control.md
Name: aes_dec_control

Overview:
- Sequencing controller for the AES-256 decryption datapath; the decrypt-side counterpart of the encryption round controller.
- On a new key it runs a forward key-expansion phase to reach the last round key and saves that key in a shadow register.
- For each block it runs the inverse rounds with the round keys walked backwards, drives the round/output register write strobes, and restores the saved last round key afterwards.

Parameters:
NUM_ROUNDS, 14, number of AES rounds; key-expansion pulses and inverse-round cycles per block.
CNT_W, 4, width of the round counter and of outRoundIdx; must hold NUM_ROUNDS.

Ports:
inClk  input  1  clock; all state changes on its rising edge.
inRstN  input  1  synchronous active-low reset.
inExtKeyWr  input  1  external key register written this cycle.
inExtDataWr  input  1  external ciphertext block presented this cycle.
outIntRoundRegExtWr  output  1  load round register from external data (initial AddRoundKey with key NUM_ROUNDS).
outIntRoundRegIntWr  output  1  load round register from inverse-round logic.
outIntDataOutRegWr  output  1  load plaintext output register.
outKeyExpFwd  output  1  key datapath steps one round key forward.
outKeyExpRev  output  1  key datapath steps one round key backward.
outKeySave  output  1  copy the current key into the last-round-key shadow register.
outKeyRestore  output  1  reload the key datapath from the shadow register.
outLastRound  output  1  current inverse round omits InvMixColumns.
outRoundIdx  output  CNT_W  current round key index.
outKeyReady  output  1  expanded key is valid; blocks are accepted.
outBusy  output  1  controller is not idle.

Behaviour:
- All outputs are combinational decodes of the state, the counter cnt, keyValid and the inputs. While inRstN=0, every output is 0.
- Reset (inRstN=0 at an edge): state=IDLE, cnt=0, keyValid=0. Reset aborts KEYEXP or DECRYPT mid-operation; no further strobes are issued and keyValid stays 0.
- IDLE: outBusy=0, outRoundIdx=0.
  - inExtKeyWr=1: keyValid<=0, cnt<=1, go to KEYEXP. This takes priority over inExtDataWr in the same cycle; the data is dropped and outIntRoundRegExtWr=0.
  - inExtDataWr=1 with keyValid=1: outIntRoundRegExtWr=1 in the same cycle, cnt<=NUM_ROUNDS-1, go to DECRYPT.
  - inExtDataWr=1 with keyValid=0: ignored; no strobe.
- KEYEXP: outBusy=1, outKeyExpFwd=1, outRoundIdx=cnt.
  - cnt<NUM_ROUNDS: cnt<=cnt+1.
  - cnt==NUM_ROUNDS: outKeySave=1, keyValid<=1, cnt<=0, go to IDLE.
  - Lasts exactly NUM_ROUNDS cycles (cnt 1..NUM_ROUNDS).
- DECRYPT: outBusy=1, outIntRoundRegIntWr=1, outKeyExpRev=1, outRoundIdx=cnt.
  - cnt>0: cnt<=cnt-1.
  - cnt==0: outLastRound=1, outIntDataOutRegWr=1, outKeyRestore=1, go to IDLE.
  - Lasts exactly NUM_ROUNDS cycles (cnt NUM_ROUNDS-1 down to 0).
- inExtKeyWr and inExtDataWr are ignored in KEYEXP and DECRYPT: no state change, keyValid unchanged.
- Latency: data write accepted in cycle T; the output register is written at the edge ending cycle T+NUM_ROUNDS (T+14). The next block is accepted in cycle T+NUM_ROUNDS+1.
- outKeyReady=keyValid. outKeyExpFwd and outKeyExpRev are never both 1.
- outKeyRestore and outKeyExpRev are asserted together on the final cycle. The restore has priority in the key datapath, which is the datapath's responsibility.
- cnt never exceeds NUM_ROUNDS; no wrap-around in either direction.

Test Plan:
- Reset, then inExtKeyWr pulse at cycle 0 -> outKeyExpFwd=1 for cycles 1..14 with outRoundIdx 1..14; outKeySave=1 only at cycle 14; outKeyReady=1 from cycle 15; outBusy=1 for cycles 1..14.
- Key ready, inExtDataWr at cycle T -> outIntRoundRegExtWr=1 at T. Cycles T+1..T+14: outIntRoundRegIntWr=1 and outRoundIdx 13..0. outLastRound, outIntDataOutRegWr and outKeyRestore are 1 only at T+14. outBusy=0 at T+15.
- inExtDataWr with outKeyReady=0 after reset -> no strobes, outBusy stays 0. inExtKeyWr and inExtDataWr in the same IDLE cycle -> KEYEXP entered, outIntRoundRegExtWr=0.
- inExtDataWr and inExtKeyWr pulsed at T+5 during DECRYPT -> ignored; sequence still completes at T+14; outKeyReady stays 1.
- inRstN=0 for one cycle at T+7 of DECRYPT -> all outputs 0 in that cycle. Afterwards IDLE with outKeyReady=0; no outIntDataOutRegWr; a following inExtDataWr is ignored.
- Back-to-back blocks (data writes at T and T+15) -> two complete 15-cycle sequences with outRoundIdx identical in both.
